// File: rtl/cpu6_timer.sv
// cpu6_timer: memory-mapped RISC-V machine timer (64-bit mtime/mtimecmp) with a level interrupt.
// Define CPU6_TMR_PRESCALE_EN to add the 8-bit tick prescaler controlled by CTRL[15:8].
module cpu6_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwriteM,
    input  logic [31:0] dataaddr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        csr_mtie_r,
    output logic        tmr_irq_r
);

    localparam logic [2:0] OFF_MTIME_LO = 3'd0;
    localparam logic [2:0] OFF_MTIME_HI = 3'd1;
    localparam logic [2:0] OFF_CMP_LO   = 3'd2;
    localparam logic [2:0] OFF_CMP_HI   = 3'd3;
    localparam logic [2:0] OFF_CTRL     = 3'd4;

    logic        sel;
    logic        wr;
    logic        wr_ctrl;
    logic [2:0]  word;
    logic        tick;
    logic [31:0] ctrl_rd;
    logic        unused_addr_bits;

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        en_q, en_d;
    logic        irq_q, irq_d;

    assign sel              = (dataaddr[31:5] == BASE_ADDR[31:5]);
    assign wr               = memwriteM & sel;
    assign word             = dataaddr[4:2];
    assign wr_ctrl          = wr && (word == OFF_CTRL);
    assign unused_addr_bits = ^dataaddr[1:0];

`ifdef CPU6_TMR_PRESCALE_EN
    logic [7:0] presc_q, presc_d;
    logic [7:0] pc_q, pc_d;

    // Tick fires when the counter reaches PRESC; the counter restarts on any CTRL write or while disabled.
    assign tick = en_q && (pc_q == presc_q);

    always_comb begin
        presc_d = presc_q;
        pc_d    = pc_q;
        if (wr_ctrl) begin
            presc_d = writedata[15:8];
            pc_d    = 8'd0;
        end else if (!en_q || tick) begin
            pc_d = 8'd0;
        end else begin
            pc_d = pc_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= 8'd0;
            pc_q    <= 8'd0;
        end else begin
            presc_q <= presc_d;
            pc_q    <= pc_d;
        end
    end

    assign ctrl_rd = {16'h0000, presc_q, 7'd0, en_q};
`else
    assign tick    = en_q;
    assign ctrl_rd = {31'd0, en_q};
`endif

    // A store to either mtime half takes priority over the increment in the same cycle.
    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        en_d       = en_q;
        if (wr && (word == OFF_MTIME_LO)) begin
            mtime_d = {mtime_q[63:32], writedata};
        end else if (wr && (word == OFF_MTIME_HI)) begin
            mtime_d = {writedata, mtime_q[31:0]};
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
        if (wr && (word == OFF_CMP_LO)) begin
            mtimecmp_d = {mtimecmp_q[63:32], writedata};
        end
        if (wr && (word == OFF_CMP_HI)) begin
            mtimecmp_d = {writedata, mtimecmp_q[31:0]};
        end
        if (wr_ctrl) begin
            en_d = writedata[0];
        end
    end

    assign irq_d = (mtime_q >= mtimecmp_q) & csr_mtie_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            en_q       <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            en_q       <= en_d;
            irq_q      <= irq_d;
        end
    end

    assign tmr_irq_r = irq_q;

    // Combinational read so the core captures the value in the access cycle.
    always_comb begin
        readdata = 32'd0;
        if (sel) begin
            case (word)
                OFF_MTIME_LO: readdata = mtime_q[31:0];
                OFF_MTIME_HI: readdata = mtime_q[63:32];
                OFF_CMP_LO:   readdata = mtimecmp_q[31:0];
                OFF_CMP_HI:   readdata = mtimecmp_q[63:32];
                OFF_CTRL:     readdata = ctrl_rd;
                default:      readdata = 32'd0;
            endcase
        end
    end

endmodule
